// File: rtl/inst_arb_pkg.sv
// Shared types and widths for the instruction-port arbiter.
package inst_arb_pkg;

  localparam int unsigned ID_W   = 2;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef logic [ID_W-1:0] req_id_t;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED_PRIO  = 1'b1
  } arb_mode_e;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

endpackage

// File: rtl/inst_port_arbiter_if.sv
// Requester-side and narrow-port signals of the instruction-port arbiter.
interface inst_port_arbiter_if
  import inst_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
);

  logic [NUM_REQ-1:0]        req_req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_gnt;
  logic [NUM_REQ-1:0]        req_rvalid;
  logic [DATA_W-1:0]         req_rdata;
  logic                      axi_i_req;
  logic [ADDR_W-1:0]         axi_i_addr;
  logic                      axi_i_gnt;
  logic                      axi_i_rvalid;
  logic [DATA_W-1:0]         axi_i_rdata;

  // Arbiter side
  modport slave (
    input  req_req, req_addr, axi_i_gnt, axi_i_rvalid, axi_i_rdata,
    output req_gnt, req_rvalid, req_rdata, axi_i_req, axi_i_addr
  );

  // Environment side (requesters plus narrow port)
  modport master (
    output req_req, req_addr, axi_i_gnt, axi_i_rvalid, axi_i_rdata,
    input  req_gnt, req_rvalid, req_rdata, axi_i_req, axi_i_addr
  );

endinterface

// File: rtl/inst_arb_id_fifo.sv
// In-order FIFO of granted requester IDs awaiting read data.
module inst_arb_id_fifo
  import inst_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  req_id_t                      i_push_id,
  input  logic                         i_pop,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output req_id_t                      o_head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  req_id_t            r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_id;
  end

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_port_arbiter.sv
// Arbitrates NUM_REQ instruction requesters onto one narrow port and routes read data back in order.
// Define INST_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.
module inst_port_arbiter
  import inst_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned OUT_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  inst_port_arbiter_if.slave               bus,
  output logic [$clog2(OUT_DEPTH+1)-1:0]   outstanding,
  output logic                             err_sticky
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

`ifdef INST_ARB_FIXED_PRIO_EN
  localparam arb_mode_e ARB_MODE = ARB_FIXED_PRIO;
`else
  localparam arb_mode_e ARB_MODE = ARB_ROUND_ROBIN;
`endif

  req_id_t             r_rr_ptr;
  lock_state_e         r_lock_state;
  lock_state_e         w_lock_state_nxt;
  req_id_t             r_lock_id;
  req_id_t             w_lock_id_nxt;
  logic                r_err;

  req_id_t             w_start;
  req_id_t             w_rr_winner;
  req_id_t             w_winner;
  logic [IDX_W-1:0]    w_idx;
  req_id_t             w_rr_next;
  logic                w_any;
  logic                w_axi_req;
  logic                w_hs;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  req_id_t             w_head;
  logic [ADDR_W-1:0]   w_addr;

  assign w_start = (ARB_MODE == ARB_ROUND_ROBIN) ? r_rr_ptr : '0;
  assign w_any   = |bus.req_req;

  // First asserted request scanning upward from w_start, wrapping at NUM_REQ
  always_comb begin : rr_pick
    logic        v_found;
    int unsigned v_idx;
    v_found     = 1'b0;
    v_idx       = 0;
    w_rr_winner = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      v_idx = 32'(w_start) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!v_found && bus.req_req[IDX_W'(v_idx)]) begin
        v_found     = 1'b1;
        w_rr_winner = ID_W'(v_idx);
      end
    end
  end

  assign w_winner  = (r_lock_state == LK_HELD) ? r_lock_id : w_rr_winner;
  assign w_idx     = IDX_W'(w_winner);
  assign w_axi_req = w_any && !w_full && !rst;
  assign w_hs      = w_axi_req && bus.axi_i_gnt;
  assign w_pop     = bus.axi_i_rvalid && !w_empty && !rst;
  assign w_rr_next = (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);

  always_comb begin
    w_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IDX_W'(i)) w_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign bus.axi_i_req  = w_axi_req;
  assign bus.axi_i_addr = w_axi_req ? w_addr : '0;
  assign bus.req_gnt    = w_hs ? (NUM_REQ'(1) << w_idx) : '0;
  assign bus.req_rvalid = w_pop ? (NUM_REQ'(1) << IDX_W'(w_head)) : '0;
  assign bus.req_rdata  = bus.axi_i_rdata;

  // Winner lock: holds selection while the narrow port stalls the request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_state <= LK_OPEN;
      r_lock_id    <= '0;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_id    <= w_lock_id_nxt;
    end
  end

  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_lock_id_nxt    = r_lock_id;
    case (r_lock_state)
      LK_OPEN: begin
        if (w_axi_req && !bus.axi_i_gnt) begin
          w_lock_state_nxt = LK_HELD;
          w_lock_id_nxt    = w_winner;
        end
      end
      LK_HELD: begin
        if (w_hs || !w_axi_req) w_lock_state_nxt = LK_OPEN;
      end
      default: w_lock_state_nxt = LK_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      if ((ARB_MODE == ARB_ROUND_ROBIN) && w_hs) r_rr_ptr <= w_rr_next;
      if (bus.axi_i_rvalid && w_empty) r_err <= 1'b1;
    end
  end

  inst_arb_id_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_id_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_hs),
    .i_push_id (w_winner),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (w_head)
  );

  assign outstanding = w_count;
  assign err_sticky  = r_err;

endmodule

// File: tb/tb_inst_port_arbiter.sv
// Bench for inst_port_arbiter: directed vector table, randomized run against a queue model, reset/lock sequence.
module tb_inst_port_arbiter;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned OUT_DEPTH = 2;
  localparam int unsigned CNT_W     = $clog2(OUT_DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_port_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();
  logic [CNT_W-1:0] outstanding;
  logic             err_sticky;

  inst_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .outstanding (outstanding),
    .err_sticky  (err_sticky)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          q[$];
  int          m_rr = 0;
  bit          m_lock = 1'b0;
  int          m_lock_id = 0;
  bit          m_err = 1'b0;
  bit          m_sync = 1'b0;
  logic [31:0] m_addr [NUM_REQ];

  typedef struct {
    bit          rst;
    logic [1:0]  req;
    bit          gnt;
    bit          rv;
    logic [31:0] rdata;
    logic [1:0]  e_gnt;
    bit          e_axi;
    logic [31:0] e_addr;
    logic [1:0]  e_rv;
    int          e_out;
    bit          e_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input logic [NUM_REQ-1:0] req, input bit g, input bit rv,
                       input logic [31:0] rd);
    rst              = r;
    bus.req_req      = req;
    for (int i = 0; i < NUM_REQ; i++) bus.req_addr[32*i +: 32] = m_addr[i];
    bus.axi_i_gnt    = g;
    bus.axi_i_rvalid = rv;
    bus.axi_i_rdata  = rd;
  endtask

  function automatic int pick(input logic [NUM_REQ-1:0] req, input int start);
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (start + k) % NUM_REQ;
      if (req[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic vec_t mk(bit r, logic [1:0] req, bit g, bit rv, logic [31:0] rd,
                              logic [1:0] eg, bit ea, logic [31:0] eaddr, logic [1:0] erv,
                              int eo, bit ee);
    vec_t v;
    v.rst = r; v.req = req; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.e_gnt = eg; v.e_axi = ea; v.e_addr = eaddr; v.e_rv = erv; v.e_out = eo; v.e_err = ee;
    return v;
  endfunction

  // One clock against the model; returns the expected grant vector
  task automatic run_cycle(input bit r, input logic [NUM_REQ-1:0] req, input bit g, input bit rv,
                           input logic [31:0] rd, output logic [NUM_REQ-1:0] gnt_exp);
    int                 win;
    bit                 full;
    bit                 e_axi;
    logic [NUM_REQ-1:0] e_gnt;
    logic [NUM_REQ-1:0] e_rv;
    logic [31:0]        e_addr;
    @(negedge clk);
    apply(r, req, g, rv, rd);
    #1;
    full   = (q.size() == OUT_DEPTH);
    e_axi  = (|req) && !full && !r;
    win    = m_lock ? m_lock_id : pick(req, m_rr);
    e_addr = e_axi ? m_addr[win] : 32'h0;
    e_gnt  = (e_axi && g) ? (NUM_REQ'(1) << win) : '0;
    e_rv   = (rv && q.size() != 0 && !r) ? (NUM_REQ'(1) << q[0]) : '0;
    chk("rnd.gnt", 32'(bus.req_gnt), 32'(e_gnt));
    chk("rnd.rvalid", 32'(bus.req_rvalid), 32'(e_rv));
    chk("rnd.axi_req", 32'(bus.axi_i_req), 32'(e_axi));
    chk("rnd.axi_addr", bus.axi_i_addr, e_addr);
    chk("rnd.rdata", bus.req_rdata, rd);
    if (m_sync) begin
      chk("rnd.outstanding", 32'(outstanding), 32'(q.size()));
      chk("rnd.err_sticky", 32'(err_sticky), 32'(m_err));
    end
    gnt_exp = e_gnt;
    @(posedge clk);
    if (r) begin
      q.delete();
      m_rr = 0; m_lock = 1'b0; m_err = 1'b0; m_sync = 1'b1;
    end else begin
      if (rv) begin
        if (q.size() != 0) void'(q.pop_front());
        else m_err = 1'b1;
      end
      if (e_axi && g) begin
        q.push_back(win);
        m_rr   = (win + 1) % NUM_REQ;
        m_lock = 1'b0;
      end else begin
        m_lock = e_axi;
        if (e_axi) m_lock_id = win;
      end
    end
  endtask

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] ge;
  bit                 r_b, g_b, rv_b;

  initial begin
    rst = 1'b1;
    apply(1'b1, '0, 1'b0, 1'b0, 32'h0);
    m_addr[0] = 32'h0000_0100;
    m_addr[1] = 32'h0000_0200;
    repeat (2) @(posedge clk);

    //          rst req   g rv rdata          gnt   axi addr   rv    out err
    tbl.push_back(mk(1, 2'b11, 1, 1, 32'h0,        2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1, 1, 32'h11,       2'b10, 1, 32'h200, 2'b01, 1, 0));
    tbl.push_back(mk(0, 2'b11, 1, 1, 32'h22,       2'b01, 1, 32'h100, 2'b10, 1, 0));
    tbl.push_back(mk(0, 2'b11, 1, 1, 32'h33,       2'b10, 1, 32'h200, 2'b01, 1, 0));
    tbl.push_back(mk(0, 2'b01, 1, 1, 32'h44,       2'b01, 1, 32'h100, 2'b10, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'h45,       2'b00, 0, 32'h0,   2'b01, 1, 0));
    tbl.push_back(mk(0, 2'b01, 0, 0, 32'h0,        2'b00, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b00, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 0, 0, 32'h0,        2'b00, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b01, 1, 32'h100, 2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b10, 1, 0, 32'h0,        2'b10, 1, 32'h200, 2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b01, 1, 0, 32'h0,        2'b00, 0, 32'h0,   2'b00, 2, 0));
    tbl.push_back(mk(0, 2'b01, 0, 1, 32'h55,       2'b00, 0, 32'h0,   2'b01, 2, 0));
    tbl.push_back(mk(0, 2'b01, 1, 0, 32'h0,        2'b01, 1, 32'h100, 2'b00, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'hAAAA0001, 2'b00, 0, 32'h0,   2'b10, 2, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'hBBBB0000, 2'b00, 0, 32'h0,   2'b01, 1, 0));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'h66,       2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 0, 32'h0,   2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 0, 32'h0,        2'b00, 0, 32'h0,   2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b01, 1, 0, 32'h0,        2'b01, 1, 32'h100, 2'b00, 0, 1));
    tbl.push_back(mk(1, 2'b11, 1, 0, 32'h0,        2'b00, 0, 32'h0,   2'b00, 1, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'h77,       2'b00, 0, 32'h0,   2'b00, 0, 0));
    tbl.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b01, 1, 32'h100, 2'b00, 0, 1));
    tbl.push_back(mk(0, 2'b00, 0, 1, 32'h88,       2'b00, 0, 32'h0,   2'b01, 1, 1));
    tbl.push_back(mk(0, 2'b11, 1, 0, 32'h0,        2'b10, 1, 32'h200, 2'b00, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      apply(v.rst, v.req, v.gnt, v.rv, v.rdata);
      #1;
      chk($sformatf("vec%0d.gnt", i), 32'(bus.req_gnt), 32'(v.e_gnt));
      chk($sformatf("vec%0d.axi_req", i), 32'(bus.axi_i_req), 32'(v.e_axi));
      chk($sformatf("vec%0d.axi_addr", i), bus.axi_i_addr, v.e_addr);
      chk($sformatf("vec%0d.rvalid", i), 32'(bus.req_rvalid), 32'(v.e_rv));
      chk($sformatf("vec%0d.rdata", i), bus.req_rdata, v.rdata);
      chk($sformatf("vec%0d.outstanding", i), 32'(outstanding), 32'(v.e_out));
      chk($sformatf("vec%0d.err_sticky", i), 32'(err_sticky), 32'(v.e_err));
      @(posedge clk);
    end

    // Randomized traffic against the queue model
    run_cycle(1'b1, '0, 1'b0, 1'b0, 32'h0, ge);
    run_cycle(1'b1, '0, 1'b0, 1'b0, 32'h0, ge);
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1'b1;
          m_addr[i] = $urandom;
        end
      end
      r_b  = ($urandom_range(0, 299) == 0);
      g_b  = ($urandom_range(0, 1) == 1);
      rv_b = (q.size() != 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 79) == 0);
      run_cycle(r_b, pend, g_b, rv_b, $urandom, ge);
      pend = pend & ~ge;
    end

    // Reset while a stalled winner is locked releases the lock
    run_cycle(1'b1, '0, 1'b0, 1'b0, 32'h0, ge);
    m_addr[0] = 32'hCAFE_0000;
    m_addr[1] = 32'hBEEF_0004;
    run_cycle(1'b0, 2'b01, 1'b0, 1'b0, 32'h0, ge);
    run_cycle(1'b0, 2'b11, 1'b0, 1'b0, 32'h0, ge);
    run_cycle(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, ge);
    @(negedge clk);
    apply(1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    #1;
    chk("lock_release.addr", bus.axi_i_addr, 32'hBEEF_0004);
    chk("lock_release.outstanding", 32'(outstanding), 32'd0);
    @(posedge clk);
    m_lock = 1'b1;
    m_lock_id = 1;
    run_cycle(1'b0, 2'b10, 1'b1, 1'b0, 32'h0, ge);
    chk("lock_release.gnt", 32'(ge), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
